// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw pins, deframes 11-bit frames and
// emits one-cycle make-code strobes (E0/F0 prefixes and break codes absorbed).
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key_in,
  output logic       key_en,
  output logic       key_ext,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             clk_s1, clk_s2, clk_s3;
  logic             dat_s1, dat_s2;
  logic             fe;
  logic [2:0]       bitcnt, bitcnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             par_bit, par_n;
  logic             byte_vld, byte_vld_n;
  logic             err_p, err_n;
  logic             tmo_p, tmo_n;
  logic             tmo;
  logic [CNT_W-1:0] cnt;
  logic             ext_flag, brk_flag;

  // Sync flops reset high to match the idle level of the PS/2 bus.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fe        = clk_s3 & ~clk_s2;
  assign tmo       = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign dbg_state = state;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= IDLE;
      bitcnt   <= 3'd0;
      shreg    <= 8'h00;
      par_bit  <= 1'b0;
      byte_vld <= 1'b0;
      err_p    <= 1'b0;
      tmo_p    <= 1'b0;
    end else begin
      state    <= state_n;
      bitcnt   <= bitcnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      byte_vld <= byte_vld_n;
      err_p    <= err_n;
      tmo_p    <= tmo_n;
    end
  end

  // Timeout takes precedence over a coincident falling edge.
  always_comb begin
    state_n    = state;
    bitcnt_n   = bitcnt;
    shreg_n    = shreg;
    par_n      = par_bit;
    byte_vld_n = 1'b0;
    err_n      = 1'b0;
    tmo_n      = 1'b0;
    if (tmo) begin
      state_n = IDLE;
      err_n   = 1'b1;
      tmo_n   = 1'b1;
    end else if (fe) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n  = DATA;
            bitcnt_n = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n  = {dat_s2, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat_s2 && (^{shreg, par_bit})) byte_vld_n = 1'b1;
          else                               err_n      = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                    cnt <= '0;
    else if (state == IDLE || fe)   cnt <= '0;
    else if (!tmo)                  cnt <= cnt + CNT_W'(1);
  end

  // Byte layer: prefixes only set flags; a break code swallows the next byte.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      key_in    <= 8'h00;
      key_en    <= 1'b0;
      key_ext   <= 1'b0;
      frame_err <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
    end else begin
      key_en    <= 1'b0;
      frame_err <= err_p;
      if (tmo_p) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_vld) begin
        if (shreg == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_flag <= 1'b1;
        end else if (brk_flag) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else begin
          key_in   <= shreg;
          key_ext  <= ext_flag;
          key_en   <= 1'b1;
          ext_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of single frames followed by
// hand sequences for the idle glitch, timeout and mid-frame reset.
module tb_ps2_key_decoder;

  localparam int TMO = 100;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic [7:0] key_in;
  logic       key_en;
  logic       key_ext;
  logic       frame_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int err_cnt  = 0;
  int overlap  = 0;
  int t_en     = 0;
  int t_err    = 0;
  int t_fall   = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .iVGA_CLK  (iVGA_CLK),
    .iRST_n    (iRST_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .key_in    (key_in),
    .key_en    (key_en),
    .key_ext   (key_ext),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 iVGA_CLK = ~iVGA_CLK;
  always @(posedge iVGA_CLK) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge
  always @(negedge iVGA_CLK) begin
    if (key_en)    begin en_cnt++;  t_en  = cyc; end
    if (frame_err) begin err_cnt++; t_err = cyc; end
    if (key_en && frame_err) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge iVGA_CLK);
  endtask

  // Driver: sends the first nbits bits of a frame; t_fall marks the last falling edge.
  task automatic send_frame(input logic [7:0] code, input logic bad_par,
                            input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      wait_neg(10);
      ps2_clk = 1'b0;
      t_fall  = cyc;
      wait_neg(20);
      ps2_clk = 1'b1;
      wait_neg(10);
    end
    ps2_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    int         exp_en;
    int         exp_err;
    logic [7:0] exp_key;
    logic       exp_ext;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int en0, err0;

    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0};
    vecs[2]  = '{8'h6B, 1'b0, 1'b0, 1, 0, 8'h6B, 1'b1};
    vecs[3]  = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h74, 1'b0};
    vecs[5]  = '{8'h6B, 1'b0, 1'b0, 1, 0, 8'h6B, 1'b1};
    vecs[6]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h6B, 1'b1};
    vecs[7]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h6B, 1'b1};
    vecs[8]  = '{8'h6B, 1'b0, 1'b0, 0, 0, 8'h6B, 1'b1};
    vecs[9]  = '{8'h6B, 1'b0, 1'b0, 1, 0, 8'h6B, 1'b0};
    vecs[10] = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0};
    vecs[11] = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b0};
    vecs[12] = '{8'h74, 1'b1, 1'b0, 0, 1, 8'h74, 1'b0};
    vecs[13] = '{8'h74, 1'b0, 1'b1, 0, 1, 8'h74, 1'b0};
    vecs[14] = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b0};
    vecs[15] = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b0};
    vecs[16] = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h74, 1'b0};
    vecs[17] = '{8'h74, 1'b0, 1'b0, 0, 0, 8'h74, 1'b0};
    vecs[18] = '{8'h75, 1'b0, 1'b0, 1, 0, 8'h75, 1'b0};

    wait_neg(3);
    check("reset_key_in",    32'(key_in),    32'h00);
    check("reset_key_en",    32'(key_en),    32'h0);
    check("reset_key_ext",   32'(key_ext),   32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_state",     32'(dbg_state), 32'h0);
    iRST_n = 1'b1;
    wait_neg(5);

    for (int v = 0; v < 19; v++) begin
      en0  = en_cnt;
      err0 = err_cnt;
      send_frame(vecs[v].code, vecs[v].bad_par, vecs[v].bad_stop, 11);
      wait_neg(30);
      check($sformatf("v%0d_en_pulses", v),  32'(en_cnt - en0),   32'(vecs[v].exp_en));
      check($sformatf("v%0d_err_pulses", v), 32'(err_cnt - err0), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_key_in", v),     32'(key_in),         32'(vecs[v].exp_key));
      check($sformatf("v%0d_key_ext", v),    32'(key_ext),        32'(vecs[v].exp_ext));
      // Strobes appear at edge k+3, i.e. the fourth rising edge after the drive
      if (vecs[v].exp_en == 1)  check($sformatf("v%0d_en_latency", v),  32'(t_en - t_fall),  32'd4);
      if (vecs[v].exp_err == 1) check($sformatf("v%0d_err_latency", v), 32'(t_err - t_fall), 32'd4);
    end

    // Falling edge with data high while idle is not a start bit
    en0  = en_cnt;
    err0 = err_cnt;
    ps2_dat = 1'b1;
    wait_neg(10);
    ps2_clk = 1'b0;
    t_fall  = cyc;
    wait_neg(20);
    ps2_clk = 1'b1;
    wait_neg(30);
    check("glitch_err_pulses", 32'(err_cnt - err0), 32'd1);
    check("glitch_en_pulses",  32'(en_cnt - en0),   32'd0);
    check("glitch_err_latency", 32'(t_err - t_fall), 32'd4);

    // Partial frame abandoned after TMO idle cycles
    en0  = en_cnt;
    err0 = err_cnt;
    send_frame(8'h72, 1'b0, 1'b0, 5);
    wait_neg(TMO + 20);
    check("tmo_err_pulses",  32'(err_cnt - err0), 32'd1);
    check("tmo_err_latency", 32'(t_err - t_fall), 32'(TMO + 5));
    check("tmo_state_idle",  32'(dbg_state),      32'd0);
    check("tmo_en_pulses",   32'(en_cnt - en0),   32'd0);
    send_frame(8'h72, 1'b0, 1'b0, 11);
    wait_neg(30);
    check("post_tmo_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("post_tmo_key_in",    32'(key_in),       32'h72);
    check("post_tmo_key_ext",   32'(key_ext),      32'h0);

    // Reset asserted mid-frame after bit 4
    en0  = en_cnt;
    err0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    iRST_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wait_neg(1);
      check($sformatf("rst_outputs_c%0d", c), 32'({key_in, key_en, key_ext, frame_err}), 32'h0);
    end
    iRST_n = 1'b1;
    wait_neg(TMO + 20);
    check("rst_state_idle",  32'(dbg_state),      32'd0);
    check("rst_no_strobe",   32'(en_cnt - en0),   32'd0);
    check("rst_no_err",      32'(err_cnt - err0), 32'd0);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    wait_neg(30);
    check("post_rst_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("post_rst_key_in",    32'(key_in),       32'h75);
    check("post_rst_key_ext",   32'(key_ext),      32'h0);

    check("en_err_overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard serial stream and turns it into one-cycle key strobes in the iVGA_CLK domain. It is the direct upstream feeder of the VGA display controller's key_in/key_en inputs, which move the falling piece. The block:
- synchronises ps2_clk/ps2_dat,
- deframes 11-bit PS/2 frames,
- strips E0 (extended) and F0 (break) prefixes,
- emits a strobe only for make codes (including typematic repeats).

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000, iVGA_CLK cycles without a ps2_clk falling edge before a partial frame is abandoned (2 ms at 25 MHz).
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- iVGA_CLK  in  1  system/pixel clock; all logic on rising edge.
- iRST_n  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock from pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data from pin, asynchronous.
- key_in  out  8  last accepted make code; holds between strobes.
- key_en  out  1  one-cycle strobe, key_in/key_ext valid.
- key_ext  out  1  key_in was E0-prefixed (arrows: 75 up, 72 down, 6B left, 74 right).
- frame_err  out  1  one-cycle strobe on framing/parity/stop/timeout error.

## Operation
Synchroniser:
- ps2_clk and ps2_dat each pass through two flops (s1, s2).
- A third clock flop (s3) gives the falling-edge pulse fe = s3 & ~s2.
- Data is sampled from s2 of ps2_dat when fe=1.

Bit FSM (advances only on fe, except timeout):
- IDLE: on fe, if data=0 (start bit) go to DATA with bitcnt=0. If data=1, stay in IDLE and pulse frame_err.
- DATA: shift data into shreg LSB first. bitcnt increments; after bit 7 go to PARITY.
- PARITY: capture the parity bit; go to STOP.
- STOP: on fe, go to IDLE. The byte is valid iff stop=1 and ^{shreg,parity}=1 (odd parity). Valid byte goes to the byte layer (byte_vld pulse); otherwise pulse frame_err and drop the byte.
- Timeout: the counter clears on every fe and in IDLE, and increments otherwise. On reaching TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear the prefix flags.

Byte layer, on byte_vld (flags ext, brk; reset 0):
- E0: set ext. No strobe.
- F0: set brk. No strobe.
- Other byte with brk=1: release code. Clear ext and brk; no strobe; key_in unchanged.
- Other byte with brk=0:
  - key_in <= byte, key_ext <= ext, key_en=1 for exactly one cycle.
  - Clear ext.
- Repeated make codes (typematic) each produce a strobe; no repeat suppression.

Reset values: key_in=8'h00, key_en=0, key_ext=0, frame_err=0, FSM=IDLE, flags=0, shreg=0, counters=0. Reset mid-frame discards the partial frame with no strobe.

## Timing
- Let edge k be the first iVGA_CLK rising edge at which ps2_clk is seen low by s1:
  - fe is high during the cycle after edge k+1.
  - The FSM acts at edge k+2.
  - key_en/frame_err are registered and go high at edge k+3, for exactly one cycle.
  - key_in/key_ext update at the same edge as key_en.
- The key_en pulse is a full iVGA_CLK period, so a consumer sampling on the falling edge sees it exactly once.
- frame_err and key_en are never high in the same cycle.
- Minimum PS/2 bit period (~60 µs) ≫ pipeline depth; no back-to-back overlap handling needed.
- No backpressure: the consumer must accept a strobe the cycle it occurs.

## Test plan
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) -> one key_en pulse, key_in=0x1C, key_ext=0, frame_err=0; key_en at k+3 after the stop-bit falling edge.
- E0 then 6B -> single key_en, key_in=0x6B, key_ext=1; no pulse for E0. Follow with 74 alone -> key_in=0x74, key_ext=0.
- E0, F0, 6B (release left) -> no key_en, key_in still 0x6B, flags cleared. Next 1C -> strobe with key_ext=0.
- 0x74 sent with wrong parity bit -> frame_err single pulse, no key_en, key_in unchanged. Stop bit 0 -> same.
- 5 bits of a frame, then idle TIMEOUT_CYCLES (set 100 in sim) -> frame_err exactly at count 100, FSM in IDLE. Next full 0x72 frame decodes correctly.
- iRST_n low for 3 cycles mid-frame (after bit 4) -> all outputs 0 during reset, no strobe. Next complete 0x75 frame -> key_in=0x75, key_en once.
